matrix_tx_scheduler: RTL and testbench

Controller in front of matrix_compiler. Round-robin arbitrates between two matrix producers (matrix A, matrix B). Forwards the granted producer's 32x32 element stream into the compiler, waits for compile_done, then waits for the Ethernet side to be idle and issues data_request. Counts the compiled frame bytes out, enforces an inter-frame gap, then re-arbitrates.

---
 rtl/matrix_tx_scheduler.sv | 244 ++++++++++++++++++++++++
 tb/tb_matrix_tx_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_tx_scheduler.sv
// Round-robin front end for matrix_compiler: grants one of two producers, forwards its element
// stream, then sequences compile -> frame request -> byte stream -> inter-frame gap.
// Optional watchdog enabled by defining MATRIX_TX_WDOG_EN (adds err_timeout port).
module matrix_tx_scheduler #(
  parameter int unsigned DIM         = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FRAME_BYTES = 1026,
  parameter int unsigned GAP_CYCLES  = 16
`ifdef MATRIX_TX_WDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES = 65536
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          src_req,
  input  logic [1:0]          src_valid,
  input  logic [1:0]          src_last,
  input  logic [2*ADDR_W-1:0] src_row,
  input  logic [2*ADDR_W-1:0] src_col,
  input  logic [2*DATA_W-1:0] src_data,
  output logic [1:0]          grant,
  output logic                mc_valid_data_in,
  output logic [ADDR_W-1:0]   mc_row_addr,
  output logic [ADDR_W-1:0]   mc_col_addr,
  output logic [DATA_W-1:0]   mc_matrix_element,
  output logic                mc_data_request,
  input  logic                mc_compile_done,
  input  logic                mc_valid_data_out,
  input  logic                tx_ready,
  output logic [1:0]          xfer_done,
  output logic                busy,
  output logic                err_count
`ifdef MATRIX_TX_WDOG_EN
  ,
  output logic                err_timeout
`endif
);

  localparam int unsigned Elems = DIM * DIM;
  localparam int unsigned EW    = $clog2(Elems) + 1;
  localparam int unsigned BW    = $clog2(FRAME_BYTES) + 1;
  localparam int unsigned GW    = $clog2(GAP_CYCLES) + 1;

  localparam logic [EW-1:0] ElemsFull = EW'(Elems);
  localparam logic [BW-1:0] FrameLast = BW'(FRAME_BYTES - 1);
  localparam logic [GW-1:0] GapLast   = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitCompile,
    StWaitTx,
    StRequest,
    StStream,
    StGap
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                gidx_q, gidx_d;
  logic                rr_q, rr_d;
  logic [EW-1:0]       elem_cnt_q, elem_cnt_d;
  logic [BW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  logic                mc_valid_q, mc_valid_d;
  logic [ADDR_W-1:0]   mc_row_q, mc_row_d;
  logic [ADDR_W-1:0]   mc_col_q, mc_col_d;
  logic [DATA_W-1:0]   mc_data_q, mc_data_d;
  logic [1:0]          xfer_done_q, xfer_done_d;
  logic                err_count_q, err_count_d;

  logic                sel_valid, sel_last;
  logic [ADDR_W-1:0]   sel_row, sel_col;
  logic [DATA_W-1:0]   sel_data;
  logic                win;
  logic [EW-1:0]       elem_inc;

`ifdef MATRIX_TX_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES) + 1;
  localparam logic [WW-1:0] WdogLast = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          err_timeout_q, err_timeout_d;
`endif

  // Only the granted producer is visible past this mux.
  always_comb begin
    sel_valid = src_valid[gidx_q];
    sel_last  = src_last[gidx_q];
    sel_row   = gidx_q ? src_row[2*ADDR_W-1:ADDR_W] : src_row[ADDR_W-1:0];
    sel_col   = gidx_q ? src_col[2*ADDR_W-1:ADDR_W] : src_col[ADDR_W-1:0];
    sel_data  = gidx_q ? src_data[2*DATA_W-1:DATA_W] : src_data[DATA_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_d        = rr_q;
    elem_cnt_d  = elem_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    mc_valid_d  = 1'b0;
    mc_row_d    = mc_row_q;
    mc_col_d    = mc_col_q;
    mc_data_d   = mc_data_q;
    xfer_done_d = 2'b00;
    err_count_d = err_count_q;
`ifdef MATRIX_TX_WDOG_EN
    wdog_cnt_d    = wdog_cnt_q;
    err_timeout_d = err_timeout_q;
`endif

    // rr_q names the preferred producer when both request.
    win      = (src_req == 2'b11) ? rr_q : ~src_req[0];
    elem_inc = (&elem_cnt_q) ? elem_cnt_q : elem_cnt_q + EW'(1);

    unique case (state_q)
      StIdle: begin
        if (src_req != 2'b00) begin
          gidx_d     = win;
          grant_d    = win ? 2'b10 : 2'b01;
          elem_cnt_d = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        if (sel_valid) begin
          mc_valid_d = 1'b1;
          mc_row_d   = sel_row;
          mc_col_d   = sel_col;
          mc_data_d  = sel_data;
          elem_cnt_d = elem_inc;
          if (sel_last) begin
            state_d = StWaitCompile;
            if (elem_inc != ElemsFull) err_count_d = 1'b1;
          end
        end
      end
      StWaitCompile: begin
        if (mc_compile_done) state_d = StWaitTx;
      end
      StWaitTx: begin
        if (tx_ready) state_d = StRequest;
      end
      StRequest: begin
        byte_cnt_d = '0;
        state_d    = StStream;
      end
      StStream: begin
        if (mc_valid_data_out) begin
          byte_cnt_d = byte_cnt_q + BW'(1);
          if (byte_cnt_q == FrameLast) begin
            xfer_done_d = grant_q;
            gap_cnt_d   = '0;
            state_d     = StGap;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          grant_d = 2'b00;
          rr_d    = ~gidx_q;
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef MATRIX_TX_WDOG_EN
    // Counter restarts on every state change; it only advances in the three wait states.
    if (state_d != state_q) begin
      wdog_cnt_d = '0;
    end else if (state_q == StWaitCompile || state_q == StWaitTx || state_q == StStream) begin
      if (wdog_cnt_q == WdogLast) begin
        wdog_cnt_d    = '0;
        gap_cnt_d     = '0;
        err_timeout_d = 1'b1;
        state_d       = StGap;
      end else begin
        wdog_cnt_d = wdog_cnt_q + WW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      grant_q       <= 2'b00;
      gidx_q        <= 1'b0;
      rr_q          <= 1'b0;
      elem_cnt_q    <= '0;
      byte_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      mc_valid_q    <= 1'b0;
      mc_row_q      <= '0;
      mc_col_q      <= '0;
      mc_data_q     <= '0;
      xfer_done_q   <= 2'b00;
      err_count_q   <= 1'b0;
`ifdef MATRIX_TX_WDOG_EN
      wdog_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      rr_q          <= rr_d;
      elem_cnt_q    <= elem_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      mc_valid_q    <= mc_valid_d;
      mc_row_q      <= mc_row_d;
      mc_col_q      <= mc_col_d;
      mc_data_q     <= mc_data_d;
      xfer_done_q   <= xfer_done_d;
      err_count_q   <= err_count_d;
`ifdef MATRIX_TX_WDOG_EN
      wdog_cnt_q    <= wdog_cnt_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  assign grant             = grant_q;
  assign mc_valid_data_in  = mc_valid_q;
  assign mc_row_addr       = mc_row_q;
  assign mc_col_addr       = mc_col_q;
  assign mc_matrix_element = mc_data_q;
  assign mc_data_request   = (state_q == StRequest);
  assign xfer_done         = xfer_done_q;
  assign busy              = (state_q != StIdle);
  assign err_count         = err_count_q;
`ifdef MATRIX_TX_WDOG_EN
  assign err_timeout       = err_timeout_q;
`endif

endmodule

// File: tb/tb_matrix_tx_scheduler.sv
// Randomized bench for matrix_tx_scheduler: drives whole transfers and checks them against a
// transaction-level model (round-robin preference, sticky error, fixed latencies, gap length).
module tb_matrix_tx_scheduler;

  localparam int Dim        = 32;
  localparam int AddrW      = 5;
  localparam int DataW      = 8;
  localparam int FrameBytes = 1026;
  localparam int GapCycles  = 16;
  localparam int Elems      = Dim * Dim;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           src_req, src_valid, src_last;
  logic [2*AddrW-1:0]   src_row, src_col;
  logic [2*DataW-1:0]   src_data;
  logic [1:0]           grant;
  logic                 mc_valid_data_in;
  logic [AddrW-1:0]     mc_row_addr, mc_col_addr;
  logic [DataW-1:0]     mc_matrix_element;
  logic                 mc_data_request, mc_compile_done, mc_valid_data_out, tx_ready;
  logic [1:0]           xfer_done;
  logic                 busy, err_count;
`ifdef MATRIX_TX_WDOG_EN
  logic                 err_timeout;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int pref = 0;
  bit err_exp = 1'b0;
  int done_pulses = 0;
  int done_exp = 0;

  always #5 clk = ~clk;

  matrix_tx_scheduler dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .src_req           (src_req),
    .src_valid         (src_valid),
    .src_last          (src_last),
    .src_row           (src_row),
    .src_col           (src_col),
    .src_data          (src_data),
    .grant             (grant),
    .mc_valid_data_in  (mc_valid_data_in),
    .mc_row_addr       (mc_row_addr),
    .mc_col_addr       (mc_col_addr),
    .mc_matrix_element (mc_matrix_element),
    .mc_data_request   (mc_data_request),
    .mc_compile_done   (mc_compile_done),
    .mc_valid_data_out (mc_valid_data_out),
    .tx_ready          (tx_ready),
    .xfer_done         (xfer_done),
    .busy              (busy),
    .err_count         (err_count)
`ifdef MATRIX_TX_WDOG_EN
    ,
    .err_timeout       (err_timeout)
`endif
  );

  always @(negedge clk) if (xfer_done != 2'b00) done_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src_req = 2'b00; src_valid = 2'b00; src_last = 2'b00;
    src_row = '0; src_col = '0; src_data = '0;
    mc_compile_done = 1'b0; mc_valid_data_out = 1'b0; tx_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_mcvalid"}, 32'(mc_valid_data_in), 0);
    check({tag, "_mcbus"}, {mc_row_addr, mc_col_addr, mc_matrix_element}, 0);
    check({tag, "_req"}, 32'(mc_data_request), 0);
    check({tag, "_xdone"}, 32'(xfer_done), 0);
    check({tag, "_err"}, 32'(err_count), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pref = 0;
    err_exp = 1'b0;
  endtask

  // One full transfer; abort_at > 0 instead resets the DUT after that many frame beats.
  task automatic transfer(input logic [1:0] req, input bit hold_req, input int n, input bit noise,
                          input bit spurious, input int tx_hold, input int abort_at);
    int w, o, k, seen, beats, gap, target;
    logic [1:0] oh;
    logic v;
    logic [AddrW-1:0] r, c;
    logic [DataW-1:0] d;
    bit got;
    w  = (req == 2'b11) ? pref : (req[0] ? 0 : 1);
    o  = 1 - w;
    oh = (w == 1) ? 2'b10 : 2'b01;
    src_req = req;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      got = (grant != 2'b00);
    end
    check("grant", 32'(grant), 32'(oh));
    if (!hold_req) src_req = 2'b00;

    k = 0;
    seen = 0;
    while (k < n) begin
      v = ($urandom_range(0, 3) != 0);
      r = AddrW'(k / Dim);
      c = AddrW'(k % Dim);
      d = (w == 0) ? (c[0] ? 8'hFF : 8'hAA) : DataW'($urandom);
      src_valid[w] = v;
      src_last[w]  = v && (k == n - 1);
      src_row[w*AddrW +: AddrW]  = r;
      src_col[w*AddrW +: AddrW]  = c;
      src_data[w*DataW +: DataW] = d;
      if (noise) begin
        src_valid[o] = 1'($urandom_range(0, 1));
        src_last[o]  = 1'($urandom_range(0, 1));
        src_row[o*AddrW +: AddrW]  = AddrW'($urandom);
        src_col[o*AddrW +: AddrW]  = AddrW'($urandom);
        src_data[o*DataW +: DataW] = 8'h55;
      end
      mc_compile_done = spurious && v && (k == n / 2);
      tick();
      check("mc_valid", 32'(mc_valid_data_in), 32'(v));
      if (v) begin
        check("mc_elem", {mc_row_addr, mc_col_addr, mc_matrix_element}, {r, c, d});
        k++;
      end
      seen += int'(mc_valid_data_in);
    end
    src_valid = 2'b00;
    src_last = 2'b00;
    mc_compile_done = 1'b0;
    check("elem_count", seen, n);

    tx_ready = 1'b1;
    repeat ($urandom_range(3, 6)) begin
      tick();
      check("mc_valid_idle", 32'(mc_valid_data_in), 0);
      check("no_req_precompile", 32'(mc_data_request), 0);
    end
    tx_ready = 1'b0;
    mc_compile_done = 1'b1;
    tick();
    mc_compile_done = 1'b0;
    repeat (tx_hold) begin
      tick();
      check("no_req_txbusy", 32'(mc_data_request), 0);
    end
    tx_ready = 1'b1;
    tick();
    check("req_pulse", 32'(mc_data_request), 1);
    tx_ready = 1'b0;
    tick();
    check("req_single", 32'(mc_data_request), 0);

    target = (abort_at > 0) ? abort_at : FrameBytes;
    beats = 0;
    while (beats < target) begin
      v = ($urandom_range(0, 4) != 0);
      mc_valid_data_out = v;
      beats += int'(v);
      tick();
      if (beats < FrameBytes) check("no_early_done", 32'(xfer_done), 0);
    end
    mc_valid_data_out = 1'b0;

    if (abort_at > 0) begin
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      apply_reset();
      check("abort_no_done", done_pulses, done_exp);
      return;
    end

    check("xfer_done", 32'(xfer_done), 32'(oh));
    done_exp++;
    gap = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i == 0) check("done_width", 32'(xfer_done), 0);
      if (grant == 2'b00) break;
      check("gap_busy", 32'(busy), 1);
      gap++;
    end
    check("gap_len", gap, GapCycles);
    check("idle_grant", 32'(grant), 0);
    check("idle_busy", 32'(busy), 0);
    err_exp = err_exp | (n != Elems);
    check("err_count", 32'(err_count), 32'(err_exp));
    check("done_pulses", done_pulses, done_exp);
    pref = 1 - w;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Producer 0 alone, spurious compile_done mid-load, Ethernet busy 50 cycles after compile.
    transfer(2'b01, 1'b0, Elems, 1'b0, 1'b1, 50, 0);

    // Contention with both requests held: grants must alternate starting from producer 0.
    apply_reset();
    for (int t = 0; t < 3; t++) transfer(2'b11, 1'b1, Elems, 1'b0, 1'b0, $urandom_range(1, 10), 0);
    src_req = 2'b00;

    // Short matrix from producer 1: sticky error, frame still sent.
    transfer(2'b10, 1'b0, 1000, 1'b0, 1'b0, $urandom_range(1, 10), 0);

    // Producer 1 toggles 0x55 noise while producer 0 owns the compiler.
    transfer(2'b01, 1'b0, Elems, 1'b1, 1'b0, $urandom_range(1, 10), 0);

    // Reset after 500 frame beats, then both request: producer 0 must win.
    transfer(2'b01, 1'b0, Elems, 1'b0, 1'b0, 3, 500);
    transfer(2'b11, 1'b0, Elems, 1'b0, 1'b0, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
